edac_secded_decoder: RTL and testbench
======================================

// Module: edac_secded_decoder
// PURPOSE
//  Read-side SECDED decoder for CoreEDAC: recomputes Hamming checks on a stored word, corrects single-bit errors, flags double errors.
//  Sits between memory read data and the consumer; the mirror of the write-side check-bit encoder (same H-matrix).
//  Fixed 2-stage pipeline with valid tagging, clock-enable stall, optional error counters.
// PARAMETERS
//  DATA_W   32  data bits per word (4..64)
//  HAM_W    6   Hamming check bits, smallest r with 2^r >= DATA_W+r+1 (derived via edac_pkg function)
//  CHK_W    7   HAM_W+1; chk_in[HAM_W] is overall parity
//  CNT_W    16  error-counter width (EDAC_ERR_CNT_EN only)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       synchronous active-high reset
//  clkEn      in   1       pipeline advance; 0 = every register holds
//  valid_in   in   1       data_in/chk_in qualify this cycle
//  data_in    in   DATA_W  received data
//  chk_in     in   CHK_W   received check bits
//  valid_out  out  1       outputs qualify
//  data_out   out  DATA_W  corrected data (raw data on DBE)
//  sbe        out  1       single-bit error corrected (incl. check/parity bit)
//  dbe        out  1       uncorrectable error
//  syndrome   out  HAM_W   registered syndrome, for logging
//  clr_cnt    in   1       clear counters (EDAC_ERR_CNT_EN only)
//  sbe_cnt    out  CNT_W   saturating SBE count (EDAC_ERR_CNT_EN only)
//  dbe_cnt    out  CNT_W   saturating DBE count (EDAC_ERR_CNT_EN only)
// BEHAVIOUR
//  Code: positions 1..DATA_W+HAM_W; check bit k at position 2^k; data bits fill remaining positions ascending (data_in[0] at position 3).
//  check[k] = XOR of data bits whose position has bit k set; overall parity = XOR of all data + HAM_W checks.
//  Stage1 (clkEn=1): s = recomputed ^ chk_in[HAM_W-1:0]; p = XOR(data_in, chk_in); register s, p, data_in, valid_in.
//  Stage2 (clkEn=1) decision:
//   s=0,p=0 -> clean: sbe=0, dbe=0, data unchanged
//   p=1,s=0 -> overall parity bit flipped: sbe=1, data unchanged
//   p=1,s=2^k -> check bit k flipped: sbe=1, data unchanged
//   p=1,s=data position -> flip that data bit: sbe=1
//   p=1,s>DATA_W+HAM_W -> dbe=1, raw data (multi-bit alias)
//   p=0,s!=0 -> dbe=1, raw data
//  Latency: exactly 2 enabled clocks valid_in -> valid_out; throughput 1 word/enabled clock; no backpressure.
//  sbe/dbe/syndrome qualified by valid_out; forced 0 when stage-2 valid=0.
//  clkEn=0: all stage registers and counters hold, outputs stable.
//  rst (sync, priority over clkEn): valid_out=0, data_out=0, sbe=0, dbe=0, syndrome=0, counters=0; in-flight words discarded.
//  sbe and dbe never both 1.
// CONFIGURATION
//  EDAC_ERR_CNT_EN defined: sbe_cnt/dbe_cnt increment once per valid_out word with sbe/dbe (when clkEn=1); saturate at all-ones;
//   clr_cnt=1 zeroes both and wins over a same-cycle increment (event lost).
//  Undefined: clr_cnt ignored, sbe_cnt/dbe_cnt tied 0, no counter registers.
// STRUCTURE
//  edac_pkg: ham_width(DATA_W), data_pos(i) map, is_pow2(), decode-class constants (CLEAN/SBE_DATA/SBE_CHK/SBE_PAR/DBE).
//  Sub-module edac_syndrome_gen: combinational HAM_W-bit check recompute + overall parity (layered XOR trees, shared with encoder map).
//  Top: two pipeline stages, correction mask decode, counters.
// TESTING (DATA_W=32, CNT_W=4, golden encoder model)
//  0xDEADBEEF + correct checks, clkEn=1 -> 2 cycles later data_out=0xDEADBEEF, sbe=0, dbe=0, syndrome=0.
//  Flip data_in[5] (pos 10) -> data_out=0xDEADBEEF, sbe=1, syndrome=6'd10; flip chk_in[2] -> sbe=1, syndrome=4; flip chk_in[6] -> sbe=1, syndrome=0.
//  Flip data_in[0] and data_in[1] -> dbe=1, sbe=0, data_out = corrupted raw word.
//  Back-to-back 20 SBE words -> sbe_cnt=15 (saturated); clr_cnt with SBE same cycle -> sbe_cnt=0.
//  Stream 4 words, clkEn=0 for 3 cycles mid-stream -> outputs frozen, then 4 words in order, none dropped/duplicated.
//  rst asserted with 2 words in flight -> next cycle valid_out=0, all outputs/counters 0; post-reset word decodes normally.

Source files
------------

// File: rtl/edac_secded_decoder_pkg.sv
// rtl/edac_secded_decoder_pkg.sv - SECDED code geometry helpers and decode classes
package edac_secded_decoder_pkg;

  localparam int MAX_DATA_W = 64;

  typedef enum logic [2:0] {
    CLEAN    = 3'd0,
    SBE_DATA = 3'd1,
    SBE_CHK  = 3'd2,
    SBE_PAR  = 3'd3,
    DBE      = 3'd4
  } dec_class_e;

  // True for 1, 2, 4, 8, ... (positions that hold Hamming check bits)
  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  // Smallest r with 2^r >= dw + r + 1
  function automatic int ham_width(input int dw);
    int r;
    r = 0;
    for (int i = 1; i < 8; i++) begin
      if (r == 0 && (1 << i) >= dw + i + 1) r = i;
    end
    return r;
  endfunction

  // Codeword position of data bit i: non-power-of-two positions, ascending from 3
  function automatic int data_pos(input int i);
    int pos;
    int cnt;
    pos = 0;
    cnt = 0;
    for (int p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == i && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  // Data bits covered by check bit k (same map the write-side encoder uses)
  function automatic logic [MAX_DATA_W-1:0] chk_mask(input int k, input int dw);
    logic [MAX_DATA_W-1:0] m;
    int p;
    m = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < dw) begin
        p = data_pos(i);
        if (((p >> k) & 1) == 1) m[i] = 1'b1;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/edac_secded_decoder_if.sv
// rtl/edac_secded_decoder_if.sv - read-data in / decoded-data out bundle for the SECDED decoder
interface edac_secded_decoder_if
  import edac_secded_decoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int HAM_W  = ham_width(DATA_W)
);
  logic              valid_in;
  logic [DATA_W-1:0] data_in;
  logic [HAM_W:0]    chk_in;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              sbe;
  logic              dbe;
  logic [HAM_W-1:0]  syndrome;

  modport master (
    output valid_in, data_in, chk_in,
    input  valid_out, data_out, sbe, dbe, syndrome
  );

  modport slave (
    input  valid_in, data_in, chk_in,
    output valid_out, data_out, sbe, dbe, syndrome
  );
endinterface

// File: rtl/edac_secded_decoder_syndrome_gen.sv
// rtl/edac_secded_decoder_syndrome_gen.sv - combinational Hamming syndrome and overall parity
module edac_syndrome_gen
  import edac_secded_decoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int HAM_W  = ham_width(DATA_W)
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [HAM_W:0]    i_chk,
  output logic [HAM_W-1:0]  o_syn,
  output logic              o_par
);

  logic [HAM_W-1:0] w_calc;

  // Each recomputed check bit is an XOR tree over the data bits whose position has bit k set
  for (genvar k = 0; k < HAM_W; k++) begin : g_chk
    localparam logic [MAX_DATA_W-1:0] MASK = chk_mask(k, DATA_W);
    assign w_calc[k] = ^(i_data & MASK[DATA_W-1:0]);
  end

  assign o_syn = w_calc ^ i_chk[HAM_W-1:0];
  // Overall parity spans data, Hamming checks and the stored parity bit; 0 when intact
  assign o_par = ^{i_data, i_chk};

endmodule

// File: rtl/edac_secded_decoder.sv
// rtl/edac_secded_decoder.sv - 2-stage SECDED read decoder; EDAC_ERR_CNT_EN adds error counters
module edac_secded_decoder
  import edac_secded_decoder_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_clkEn,
  input  logic                  i_clr_cnt,
  edac_secded_decoder_if.slave  io,
  output logic [CNT_W-1:0]      o_sbe_cnt,
  output logic [CNT_W-1:0]      o_dbe_cnt
);

  localparam int HAM_W = ham_width(DATA_W);
  localparam int NPOS  = DATA_W + HAM_W;

  logic [HAM_W-1:0]  w_syn;
  logic              w_par;
  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_data;
  logic [HAM_W-1:0]  r_s1_syn;
  logic              r_s1_par;
  dec_class_e        w_class;
  logic [DATA_W-1:0] w_flip;
  logic [DATA_W-1:0] w_corr;
  logic              r_valid_out;
  logic [DATA_W-1:0] r_data_out;
  logic              r_sbe;
  logic              r_dbe;
  logic [HAM_W-1:0]  r_syndrome;

  edac_syndrome_gen #(
    .DATA_W (DATA_W),
    .HAM_W  (HAM_W)
  ) u_syn (
    .i_data (io.data_in),
    .i_chk  (io.chk_in),
    .o_syn  (w_syn),
    .o_par  (w_par)
  );

  // Stage 1: capture syndrome, parity and raw word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_syn   <= '0;
      r_s1_par   <= 1'b0;
    end else if (i_clkEn) begin
      r_s1_valid <= io.valid_in;
      r_s1_data  <= io.data_in;
      r_s1_syn   <= w_syn;
      r_s1_par   <= w_par;
    end
  end

  // Classify the error from (syndrome, parity); out-of-range syndromes are multi-bit aliases
  always_comb begin
    w_class = CLEAN;
    if (!r_s1_par) begin
      w_class = (r_s1_syn == '0) ? CLEAN : DBE;
    end else if (r_s1_syn == '0) begin
      w_class = SBE_PAR;
    end else if (is_pow2(int'(r_s1_syn))) begin
      w_class = SBE_CHK;
    end else if (int'(r_s1_syn) <= NPOS) begin
      w_class = SBE_DATA;
    end else begin
      w_class = DBE;
    end
  end

  // One-hot correction mask: the data bit whose codeword position equals the syndrome
  for (genvar i = 0; i < DATA_W; i++) begin : g_flip
    localparam int POS = data_pos(i);
    assign w_flip[i] = (r_s1_syn == HAM_W'(POS));
  end

  assign w_corr = (w_class == SBE_DATA) ? (r_s1_data ^ w_flip) : r_s1_data;

  // Stage 2: registered outputs; flags and syndrome only carry meaning with a valid word
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid_out <= 1'b0;
      r_data_out  <= '0;
      r_sbe       <= 1'b0;
      r_dbe       <= 1'b0;
      r_syndrome  <= '0;
    end else if (i_clkEn) begin
      r_valid_out <= r_s1_valid;
      r_data_out  <= w_corr;
      r_sbe       <= r_s1_valid &&
                     (w_class == SBE_DATA || w_class == SBE_CHK || w_class == SBE_PAR);
      r_dbe       <= r_s1_valid && (w_class == DBE);
      r_syndrome  <= r_s1_valid ? r_s1_syn : '0;
    end
  end

  assign io.valid_out = r_valid_out;
  assign io.data_out  = r_data_out;
  assign io.sbe       = r_sbe;
  assign io.dbe       = r_dbe;
  assign io.syndrome  = r_syndrome;

`ifdef EDAC_ERR_CNT_EN
  logic [CNT_W-1:0] r_sbe_cnt;
  logic [CNT_W-1:0] r_dbe_cnt;

  // Saturating counters of output words with errors; a clear drops a same-cycle event
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr_cnt) begin
      r_sbe_cnt <= '0;
      r_dbe_cnt <= '0;
    end else if (i_clkEn) begin
      if (r_valid_out && r_sbe && (r_sbe_cnt != '1)) r_sbe_cnt <= r_sbe_cnt + 1'b1;
      if (r_valid_out && r_dbe && (r_dbe_cnt != '1)) r_dbe_cnt <= r_dbe_cnt + 1'b1;
    end
  end

  assign o_sbe_cnt = r_sbe_cnt;
  assign o_dbe_cnt = r_dbe_cnt;
`else
  logic w_unused_clr;
  assign w_unused_clr = i_clr_cnt;
  assign o_sbe_cnt    = '0;
  assign o_dbe_cnt    = '0;
`endif

endmodule

// File: tb/tb_edac_secded_decoder.sv
// tb/tb_edac_secded_decoder.sv - self-checking bench for edac_secded_decoder
module tb_edac_secded_decoder;

  localparam int DW    = 32;
  localparam int HW    = 6;
  localparam int CNT_W = 4;
`ifdef EDAC_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             clk_en;
  logic             clr_cnt;
  logic [CNT_W-1:0] sbe_cnt;
  logic [CNT_W-1:0] dbe_cnt;

  always #5 clk = ~clk;

  edac_secded_decoder_if #(.DATA_W(DW), .HAM_W(HW)) bus ();

  edac_secded_decoder #(
    .DATA_W (DW),
    .CNT_W  (CNT_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clkEn   (clk_en),
    .i_clr_cnt (clr_cnt),
    .io        (bus),
    .o_sbe_cnt (sbe_cnt),
    .o_dbe_cnt (dbe_cnt)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sbe;
    logic        dbe;
    logic [5:0]  syn;
  } exp_t;

  typedef struct {
    logic [31:0] d;
    logic [6:0]  cx;
    logic [31:0] dx;
    logic [31:0] ed;
    logic        es;
    logic        edb;
    logic [5:0]  syn;
  } vec_t;

  exp_t  sb_q[$];
  exp_t  m_e;
  int    n_cmp = 0;
  int    n_bad = 0;
  vec_t  tbl[12];
  logic [63:0] snap;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Golden encoder: lay out the codeword explicitly, then compute checks and overall parity
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [38:0] cw;
    logic [6:0]  c;
    int          j;
    cw = '0;
    c  = '0;
    j  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[j];
        j++;
      end
    end
    for (int k = 0; k < 6; k++)
      for (int p = 1; p <= 38; p++)
        if (((p >> k) & 1) == 1 && (p & (p - 1)) != 0) c[k] = c[k] ^ cw[p];
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  function automatic int pos_of(input int b);
    int cnt;
    int r;
    cnt = 0;
    r   = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == b) r = p;
        cnt++;
      end
    end
    return r;
  endfunction

  task automatic drive(input logic v, input logic [31:0] d, input logic [6:0] cx, input logic [31:0] dx);
    bus.valid_in = v;
    bus.data_in  = d ^ dx;
    bus.chk_in   = enc(d) ^ cx;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] cx, input logic [31:0] dx, input exp_t e);
    @(negedge clk);
    clk_en = 1'b1;
    drive(1'b1, d, cx, dx);
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      clk_en       = 1'b1;
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) idle(1);
    idle(2);
    check("queue_drained", 64'(sb_q.size()), 64'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, 64'({bus.valid_out, bus.data_out, bus.sbe, bus.dbe, bus.syndrome, sbe_cnt, dbe_cnt}), 64'd0);
  endtask

  // Scoreboard monitor: a new output appears only after an enabled, non-reset edge
  always @(posedge clk) begin
    #1;
    if (!rst && clk_en) begin
      if (bus.valid_out) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got data 0x%0h with empty queue", bus.data_out);
        end else begin
          m_e = sb_q.pop_front();
          check("data_out", 64'(bus.data_out), 64'(m_e.data));
          check("sbe", 64'(bus.sbe), 64'(m_e.sbe));
          check("dbe", 64'(bus.dbe), 64'(m_e.dbe));
          check("syndrome", 64'(bus.syndrome), 64'(m_e.syn));
        end
      end else begin
        check("idle_flags", 64'({bus.sbe, bus.dbe, bus.syndrome}), 64'd0);
      end
    end
  end

  initial begin
    tbl[0]  = '{32'hDEADBEEF, 7'h00, 32'h0,          32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
    tbl[1]  = '{32'hDEADBEEF, 7'h00, 32'h0000_0020,  32'hDEADBEEF, 1'b1, 1'b0, 6'd10};
    tbl[2]  = '{32'hDEADBEEF, 7'h04, 32'h0,          32'hDEADBEEF, 1'b1, 1'b0, 6'd4};
    tbl[3]  = '{32'hDEADBEEF, 7'h40, 32'h0,          32'hDEADBEEF, 1'b1, 1'b0, 6'd0};
    tbl[4]  = '{32'hDEADBEEF, 7'h00, 32'h0000_0003,  32'hDEADBEEC, 1'b0, 1'b1, 6'd6};
    tbl[5]  = '{32'hDEADBEEF, 7'h00, 32'h8000_0000,  32'hDEADBEEF, 1'b1, 1'b0, 6'd38};
    tbl[6]  = '{32'h00000000, 7'h00, 32'h0,          32'h00000000, 1'b0, 1'b0, 6'd0};
    tbl[7]  = '{32'hFFFFFFFF, 7'h01, 32'h0,          32'hFFFFFFFF, 1'b1, 1'b0, 6'd1};
    tbl[8]  = '{32'h12345678, 7'h00, 32'h0400_0000,  32'h12345678, 1'b1, 1'b0, 6'd33};
    tbl[9]  = '{32'h12345678, 7'h00, 32'h8000_0801,  32'h92345E79, 1'b0, 1'b1, 6'd52};
    tbl[10] = '{32'hA5A5A5A5, 7'h40, 32'h0000_0010,  32'hA5A5A5B5, 1'b0, 1'b1, 6'd9};
    tbl[11] = '{32'h5A5A5A5A, 7'h00, 32'h0000_0001,  32'h5A5A5A5A, 1'b1, 1'b0, 6'd3};

    rst     = 1'b1;
    clk_en  = 1'b1;
    clr_cnt = 1'b0;
    drive(1'b0, 32'h0, 7'h0, 32'h0);
    repeat (3) @(negedge clk);
    check_all_zero("reset_state");
    rst = 1'b0;
    idle(1);

    // Table of single/double/alias cases, back to back
    for (int i = 0; i < 12; i++)
      send(tbl[i].d, tbl[i].cx, tbl[i].dx, '{tbl[i].ed, tbl[i].es, tbl[i].edb, tbl[i].syn});
    drain();
    check("sbe_cnt_table", 64'(sbe_cnt), CNT_EN ? 64'd7 : 64'd0);
    check("dbe_cnt_table", 64'(dbe_cnt), CNT_EN ? 64'd3 : 64'd0);

    // Clear, then 20 SBE words back to back -> saturate
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("cnt_cleared", 64'({sbe_cnt, dbe_cnt}), 64'd0);
    for (int i = 0; i < 20; i++) begin
      int          b;
      logic [31:0] d;
      b = $urandom_range(0, 31);
      d = $urandom;
      send(d, 7'h00, 32'(1) << b, '{d, 1'b1, 1'b0, 6'(pos_of(b))});
    end
    drain();
    check("sbe_cnt_sat", 64'(sbe_cnt), CNT_EN ? 64'd15 : 64'd0);
    check("dbe_cnt_zero", 64'(dbe_cnt), 64'd0);

    // Clear in the same cycle an SBE word would be counted
    send(32'hCAFEF00D, 7'h00, 32'h0000_0100, '{32'hCAFEF00D, 1'b1, 1'b0, 6'(pos_of(8))});
    idle(1);
    @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    idle(2);
    check("sbe_cnt_clr_wins", 64'(sbe_cnt), 64'd0);

    // Stall mid-stream: outputs frozen, every word appears exactly once
    send(32'h11111111, 7'h00, 32'h0,         '{32'h11111111, 1'b0, 1'b0, 6'd0});
    send(32'h22222222, 7'h00, 32'h0000_0004, '{32'h22222222, 1'b1, 1'b0, 6'd6});
    @(negedge clk);
    snap   = 64'({bus.valid_out, bus.sbe, bus.dbe, bus.syndrome, bus.data_out});
    clk_en = 1'b0;
    drive(1'b1, 32'h33333333, 7'h00, 32'h0000_0003);
    sb_q.push_back('{32'h33333330, 1'b0, 1'b1, 6'd6});
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_frozen", 64'({bus.valid_out, bus.sbe, bus.dbe, bus.syndrome, bus.data_out}), snap);
    end
    clk_en = 1'b1;
    send(32'h44444444, 7'h02, 32'h0, '{32'h44444444, 1'b1, 1'b0, 6'd2});
    drain();

    // Reset with words in flight, clkEn low to show reset priority
    send(32'h55555555, 7'h00, 32'h0, '{32'h55555555, 1'b0, 1'b0, 6'd0});
    @(negedge clk);
    drive(1'b1, 32'h66666666, 7'h00, 32'h0000_0001);
    @(negedge clk);
    rst    = 1'b1;
    clk_en = 1'b0;
    drive(1'b1, 32'h77777777, 7'h00, 32'h0);
    @(negedge clk);
    check_all_zero("reset_in_flight");
    rst = 1'b0;
    idle(1);
    send(32'h89ABCDEF, 7'h00, 32'h0000_8000, '{32'h89ABCDEF, 1'b1, 1'b0, 6'(pos_of(15))});
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
